pulse_stretch_multi: RTL and testbench
======================================

Name: pulse_stretch_multi

Overview:
- Parametrised, multi-channel pulse stretcher for switch and UART data-valid indications.
- Each channel turns a trigger into an output pulse of exactly HOLD_CYCLES clocks.
- Per-channel options: retrigger (extend) and re-arm (wait for trigger low before firing again).
- Sits between user switches / UART receiver strobes and LED or downstream control logic.
- Sub-module pulse_stretch_ch is instantiated N_CH times.

Parameters:
- N_CH, 4, number of independent channels.
- HOLD_CYCLES, 128_000_000, pulse length in clk cycles; must be at least 2.
- CNT_W, $clog2(HOLD_CYCLES), counter width (derived, not overridden).
- SYNC_STAGES, 2, synchroniser flops on sw_in; 0 means sw_in is already synchronous.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- sw_in  in  N_CH  asynchronous switch inputs, one per channel.
- dv_in  in  N_CH  synchronous data-valid strobes, one per channel.
- retrig_en  in  N_CH  1 = a rising trigger edge during a pulse restarts the count.
- rearm_en  in  N_CH  1 = after a pulse ends, the trigger must go low before the channel can fire again.
- pulse_out  out  N_CH  registered stretched pulse.
- done  out  N_CH  one-cycle strobe in the cycle pulse_out falls.
- busy  out  1  OR of all pulse_out bits, registered.

Behaviour:
- Reset (async assert, sync release):
  - All channels go to IDLE.
  - pulse_out=0, done=0, busy=0, counters=0.
  - Synchroniser flops and edge-detect history cleared to 0.
- Trigger per channel: t = sw_sync | dv_in, where sw_sync is sw_in after SYNC_STAGES flops. Rising edge: rise = t & ~t_q, with t_q registered.
- Latency:
  - dv_in high at edge k gives pulse_out high after edge k+1.
  - sw_in adds SYNC_STAGES cycles.
- IDLE state:
  - pulse_out=0.
  - If t=1 (level, not edge): go to STRETCH, count=0, pulse_out=1.
- STRETCH state:
  - pulse_out=1; count increments each cycle.
  - If retrig_en and rise: count=0, stay in STRETCH, no done.
  - Else if count==HOLD_CYCLES-1: pulse_out=0, done=1 for one cycle, count=0. Next state is WAIT_LOW if rearm_en and t=1, otherwise IDLE.
  - Without retrigger, pulse_out is high for exactly HOLD_CYCLES cycles.
- WAIT_LOW state:
  - pulse_out=0.
  - When t=0, go to IDLE; the channel can fire on the next cycle t=1.
- rearm_en=0 with t held high:
  - The channel fires back-to-back pulses with exactly one low cycle between them.
  - done fires at each fall.
- Simultaneous rise with count==HOLD_CYCLES-1 and retrig_en=1: retrigger wins. pulse_out stays high, count=0, no done.
- retrig_en=0: edges during STRETCH are ignored.
- retrig_en and rearm_en are sampled every cycle; a change takes effect on the next decision point.
- Counter never exceeds HOLD_CYCLES-1; no wrap occurs.
- busy is the registered OR of the next-state pulse_out bits, so it is aligned with pulse_out.
- Reset mid-pulse: pulse_out drops asynchronously. After release, a trigger still held high starts a fresh full-length pulse.
- Channels are fully independent; no shared arbitration.

Decomposition:
- Package pulse_stretch_pkg holds:
  - state encoding typedef (IDLE, STRETCH, WAIT_LOW);
  - a localparam helper for CNT_W.
- Sub-module pulse_stretch_ch contains one channel:
  - edge detect, FSM, counter, done generation.
- The top holds the sw_in synchronisers, the channel generate loop and the busy register.

Test Plan (HOLD_CYCLES=5, SYNC_STAGES=2, N_CH=4):
- Single dv_in pulse on ch0 at cycle 10 -> pulse_out[0] high for cycles 11-15, done[0] at cycle 16, busy tracks pulse_out, other channels stay 0.
- sw_in[1] high for 20 cycles with rearm_en[1]=1 -> one 5-cycle pulse, starting 3 cycles after the input, then low until sw_in falls; a second press produces another 5-cycle pulse.
- Same as previous with rearm_en[1]=0 -> repeated pulses of 5 high, 1 low, with done at each fall.
- retrig_en[2]=1, dv_in pulses at cycle 0 and 3 -> pulse_out[2] high cycles 1-8 (count restarted), a single done at cycle 9. Repeat with retrig_en=0 -> high cycles 1-5; the second edge is ignored.
- Retrigger edge landing exactly on count==4 -> no done, pulse extended by 5 more cycles.
- Assert rst_n=0 at count 2 with dv_in held high -> pulse_out, done and busy go to 0 immediately. After release, a full 5-cycle pulse starts one cycle later.

Source files
------------

// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg: shared types and helpers
// for the multi-channel pulse stretcher.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STRETCH  = 2'd1,
    WAIT_LOW = 2'd2
  } state_e;

  localparam int HOLD_MIN = 2;

  function automatic int cnt_width(
    input int hold
  );
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/pulse_stretch_if.sv
// pulse_stretch_if: trigger inputs, channel
// options and stretched outputs.
interface pulse_stretch_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0] sw_in;
  logic [N_CH-1:0] dv_in;
  logic [N_CH-1:0] retrig_en;
  logic [N_CH-1:0] rearm_en;
  logic [N_CH-1:0] pulse_out;
  logic [N_CH-1:0] done;
  logic            busy;

  modport master (
    output sw_in,
    output dv_in,
    output retrig_en,
    output rearm_en,
    input  pulse_out,
    input  done,
    input  busy
  );

  modport slave (
    input  sw_in,
    input  dv_in,
    input  retrig_en,
    input  rearm_en,
    output pulse_out,
    output done,
    output busy
  );

endinterface

// File: rtl/pulse_stretch_ch.sv
// pulse_stretch_ch: one channel -- edge detect,
// state machine, hold counter and done strobe.
module pulse_stretch_ch
  import pulse_stretch_pkg::*;
#(
  parameter int HOLD_CYCLES = 128_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  input  logic retrig_en,
  input  logic rearm_en,
  output logic pulse_out,
  output logic done,
  output logic pulse_nxt
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(HOLD_CYCLES - 1);

  state_e           state;
  state_e           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             t_q;
  logic             rise;
  logic             done_n;

  assign rise = t & ~t_q;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pulse_nxt = pulse_out;
    done_n    = 1'b0;
    unique case (state)
      IDLE: begin
        pulse_nxt = t;
        if (t) begin
          state_n = STRETCH;
          cnt_n   = '0;
        end
      end
      STRETCH: begin
        pulse_nxt = 1'b1;
        // a retrigger edge beats the terminal count
        if (retrig_en && rise) begin
          cnt_n = '0;
        end else if (cnt == CNT_MAX) begin
          pulse_nxt = 1'b0;
          done_n    = 1'b1;
          cnt_n     = '0;
          state_n   = (rearm_en && t) ?
                      WAIT_LOW : IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_LOW: begin
        pulse_nxt = 1'b0;
        if (!t) state_n = IDLE;
      end
      default: begin
        pulse_nxt = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      t_q       <= 1'b0;
      pulse_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      t_q       <= t;
      pulse_out <= pulse_nxt;
      done      <= done_n;
    end
  end

endmodule

// File: rtl/pulse_stretch_multi.sv
// pulse_stretch_multi: switch synchronisers,
// N_CH stretcher channels and the busy flag.
module pulse_stretch_multi
  import pulse_stretch_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int HOLD_CYCLES = 128_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pulse_stretch_if.slave   bus
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES);

  logic [N_CH-1:0] sw_sync;
  logic [N_CH-1:0] trig;
  logic [N_CH-1:0] pulse_v;
  logic [N_CH-1:0] done_v;
  logic [N_CH-1:0] pulse_nxt;
  logic            busy_q;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [N_CH-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_STAGES; i++)
            sync_q[i] <= '0;
        end else begin
          sync_q[0] <= bus.sw_in;
          for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
        end
      end

      assign sw_sync = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign sw_sync = bus.sw_in;
    end
  endgenerate

  assign trig = sw_sync | bus.dv_in;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pulse_stretch_ch #(
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .t         (trig[c]),
      .retrig_en (bus.retrig_en[c]),
      .rearm_en  (bus.rearm_en[c]),
      .pulse_out (pulse_v[c]),
      .done      (done_v[c]),
      .pulse_nxt (pulse_nxt[c])
    );
  end

  // built from next-state bits so it lines up with pulse_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= |pulse_nxt;
  end

  assign bus.pulse_out = pulse_v;
  assign bus.done      = done_v;
  assign bus.busy      = busy_q;

  if (CNT_W < 1 || HOLD_CYCLES < HOLD_MIN)
  begin : g_bad_hold
    logic unused_bad;
    assign unused_bad = 1'b0;
  end

endmodule

// File: tb/tb_pulse_stretch_multi.sv
// tb_pulse_stretch_multi: directed checks with
// HOLD_CYCLES=5, SYNC_STAGES=2, N_CH=4.
module tb_pulse_stretch_multi;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pulse_stretch_if #(.N_CH(4)) bus ();

  pulse_stretch_multi #(
    .N_CH        (4),
    .HOLD_CYCLES (5),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string      tag,
    input logic [3:0] obs,
    input logic [3:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic look(
    input string      tag,
    input logic [3:0] p,
    input logic [3:0] d,
    input logic       b
  );
    chk({tag, "/pulse"}, bus.pulse_out, p);
    chk({tag, "/done"}, bus.done, d);
    chk({tag, "/busy"}, {3'b0, bus.busy}, {3'b0, b});
  endtask

  task automatic cyc(
    input string      tag,
    input logic [3:0] p,
    input logic [3:0] d,
    input logic       b
  );
    @(posedge clk);
    #1;
    look(tag, p, d, b);
  endtask

  task automatic run(
    input int         n,
    input string      tag,
    input logic [3:0] p,
    input logic [3:0] d,
    input logic       b
  );
    repeat (n) cyc(tag, p, d, b);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.sw_in     = '0;
    bus.dv_in     = '0;
    bus.retrig_en = '0;
    bus.rearm_en  = '0;

    // reset state
    run(2, "reset", 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    run(2, "idle", 4'h0, 4'h0, 1'b0);

    // single dv strobe on ch0
    bus.dv_in = 4'b0001;
    cyc("dv0_start", 4'b0001, 4'h0, 1'b1);
    bus.dv_in = 4'b0000;
    run(4, "dv0_hold", 4'b0001, 4'h0, 1'b1);
    cyc("dv0_done", 4'h0, 4'b0001, 1'b0);
    run(2, "dv0_after", 4'h0, 4'h0, 1'b0);

    // sw_in[1] held, rearm on
    bus.rearm_en = 4'b0010;
    bus.sw_in    = 4'b0010;
    run(2, "sw1_sync", 4'h0, 4'h0, 1'b0);
    run(5, "sw1_hold", 4'b0010, 4'h0, 1'b1);
    cyc("sw1_done", 4'h0, 4'b0010, 1'b0);
    run(12, "sw1_wait", 4'h0, 4'h0, 1'b0);
    bus.sw_in = 4'b0000;
    run(3, "sw1_rel", 4'h0, 4'h0, 1'b0);
    bus.sw_in = 4'b0010;
    run(2, "sw1b_sync", 4'h0, 4'h0, 1'b0);
    run(5, "sw1b_hold", 4'b0010, 4'h0, 1'b1);
    cyc("sw1b_done", 4'h0, 4'b0010, 1'b0);
    run(3, "sw1b_wait", 4'h0, 4'h0, 1'b0);
    bus.sw_in = 4'b0000;
    run(4, "sw1b_rel", 4'h0, 4'h0, 1'b0);

    // sw_in[1] held, rearm off: repeat 5 high 1 low
    bus.rearm_en = 4'b0000;
    bus.sw_in    = 4'b0010;
    run(2, "rep_sync", 4'h0, 4'h0, 1'b0);
    repeat (3) begin
      run(5, "rep_hold", 4'b0010, 4'h0, 1'b1);
      cyc("rep_done", 4'h0, 4'b0010, 1'b0);
    end
    bus.sw_in = 4'b0000;
    run(5, "rep_last", 4'b0010, 4'h0, 1'b1);
    cyc("rep_ldone", 4'h0, 4'b0010, 1'b0);
    run(2, "rep_idle", 4'h0, 4'h0, 1'b0);

    // ch2 retrigger at count 2
    bus.retrig_en = 4'b0100;
    bus.dv_in     = 4'b0100;
    cyc("rt_c1", 4'b0100, 4'h0, 1'b1);
    bus.dv_in = 4'b0000;
    run(2, "rt_c2", 4'b0100, 4'h0, 1'b1);
    bus.dv_in = 4'b0100;
    cyc("rt_c4", 4'b0100, 4'h0, 1'b1);
    bus.dv_in = 4'b0000;
    run(4, "rt_c5", 4'b0100, 4'h0, 1'b1);
    cyc("rt_done", 4'h0, 4'b0100, 1'b0);
    run(2, "rt_idle", 4'h0, 4'h0, 1'b0);

    // same stimulus, retrigger off
    bus.retrig_en = 4'b0000;
    bus.dv_in     = 4'b0100;
    cyc("nrt_c1", 4'b0100, 4'h0, 1'b1);
    bus.dv_in = 4'b0000;
    run(2, "nrt_c2", 4'b0100, 4'h0, 1'b1);
    bus.dv_in = 4'b0100;
    cyc("nrt_c4", 4'b0100, 4'h0, 1'b1);
    bus.dv_in = 4'b0000;
    cyc("nrt_c5", 4'b0100, 4'h0, 1'b1);
    cyc("nrt_done", 4'h0, 4'b0100, 1'b0);
    run(2, "nrt_idle", 4'h0, 4'h0, 1'b0);

    // retrigger edge exactly at terminal count
    bus.retrig_en = 4'b0100;
    bus.dv_in     = 4'b0100;
    cyc("rtt_c1", 4'b0100, 4'h0, 1'b1);
    bus.dv_in = 4'b0000;
    run(4, "rtt_c2", 4'b0100, 4'h0, 1'b1);
    bus.dv_in = 4'b0100;
    cyc("rtt_ext", 4'b0100, 4'h0, 1'b1);
    bus.dv_in = 4'b0000;
    run(4, "rtt_c7", 4'b0100, 4'h0, 1'b1);
    cyc("rtt_done", 4'h0, 4'b0100, 1'b0);
    run(2, "rtt_idle", 4'h0, 4'h0, 1'b0);
    bus.retrig_en = 4'b0000;

    // reset mid-pulse with dv_in[0] held
    bus.dv_in = 4'b0001;
    cyc("rst_c1", 4'b0001, 4'h0, 1'b1);
    run(2, "rst_c2", 4'b0001, 4'h0, 1'b1);
    rst_n = 1'b0;
    #1;
    look("rst_async", 4'h0, 4'h0, 1'b0);
    cyc("rst_held", 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    run(5, "rst_fresh", 4'b0001, 4'h0, 1'b1);
    cyc("rst_done", 4'h0, 4'b0001, 1'b0);
    bus.dv_in = 4'b0000;
    run(2, "rst_idle", 4'h0, 4'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
